// File: rtl/alu_dispatch_controller_pkg.sv
// alu_dispatch_controller_pkg: opcode map, execute-unit indices and FSM states shared by the dispatch controller and decode
package alu_dispatch_controller_pkg;
   localparam int UNIT_W = 2;
   typedef logic [UNIT_W-1:0] unit_idx_t;
   localparam logic [6:0] OPCODE_LUI = 7'h37;
   localparam logic [6:0] OPCODE_AUIPC = 7'h17;
   localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
   localparam logic [6:0] OPCODE_OP = 7'h33;
   localparam unit_idx_t UNIT_UPPER_IMM = 2'd0;
   localparam unit_idx_t UNIT_OP_IMM = 2'd1;
   localparam unit_idx_t UNIT_OP = 2'd2;
   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
endpackage

// File: rtl/alu_dispatch_controller_if.sv
// alu_dispatch_controller_if: decode, execute-unit and writeback signals of the dispatch controller
// master is the controller side; ALU_DISPATCH_PERF_COUNTERS_EN adds the performance counter outputs
interface alu_dispatch_controller_if #(parameter int NUM_UNITS = 3);
   logic instr_valid;
   logic instr_ready;
   logic [6:0] opcode;
   logic [4:0] rd_index;
   logic [NUM_UNITS-1:0] unit_enable;
   logic [32*NUM_UNITS-1:0] unit_result;
   logic wb_valid;
   logic wb_ready;
   logic [4:0] wb_rd_index;
   logic [31:0] wb_value;
   logic illegal_opcode;
`ifdef ALU_DISPATCH_PERF_COUNTERS_EN
   logic [31:0] perf_issued;
   logic [31:0] perf_wb_stall;
`endif
   modport master (
      input instr_valid, opcode, rd_index, unit_result, wb_ready,
      output instr_ready, unit_enable, wb_valid, wb_rd_index, wb_value, illegal_opcode
`ifdef ALU_DISPATCH_PERF_COUNTERS_EN
      , output perf_issued, perf_wb_stall
`endif
   );
   modport slave (
      output instr_valid, opcode, rd_index, unit_result, wb_ready,
      input instr_ready, unit_enable, wb_valid, wb_rd_index, wb_value, illegal_opcode
`ifdef ALU_DISPATCH_PERF_COUNTERS_EN
      , input perf_issued, perf_wb_stall
`endif
   );
endinterface

// File: rtl/alu_opcode_select.sv
// alu_opcode_select: maps an RV32I opcode to its execute-unit index and flags unsupported opcodes
module alu_opcode_select
   import alu_dispatch_controller_pkg::*;
(
   input  logic [6:0] opcode,
   output unit_idx_t  unit,
   output logic       illegal
);
   assign unit = (opcode == OPCODE_OP) ? UNIT_OP : (opcode == OPCODE_OP_IMM) ? UNIT_OP_IMM : UNIT_UPPER_IMM;
   assign illegal = !(opcode inside {OPCODE_LUI, OPCODE_AUIPC, OPCODE_OP_IMM, OPCODE_OP});
endmodule

// File: rtl/alu_dispatch_controller.sv
// alu_dispatch_controller: issues one instruction at a time to a single execute unit and hands its result to writeback
// ALU_DISPATCH_PERF_COUNTERS_EN adds issue and writeback-stall counters
module alu_dispatch_controller
   import alu_dispatch_controller_pkg::*;
#(
   parameter int UNIT_LATENCY = 1,
   parameter int NUM_UNITS = 3
)(
   input logic clock,
   input logic reset_n,
   alu_dispatch_controller_if.master bus
);
   localparam logic [2:0] LAST = 3'(UNIT_LATENCY - 1);
   state_t state;
   unit_idx_t sel_unit, sel_q;
   logic sel_illegal;
   logic ready_q, wb_valid_q, illegal_q;
   logic [NUM_UNITS-1:0] enable_q;
   logic [4:0] rd_q, wb_rd_q;
   logic [31:0] wb_value_q;
   logic [2:0] count;
   alu_opcode_select u_select (.opcode(bus.opcode), .unit(sel_unit), .illegal(sel_illegal));
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= IDLE;
         ready_q <= 1'b1;
         enable_q <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q <= '0;
         wb_value_q <= '0;
         illegal_q <= 1'b0;
         count <= '0;
         sel_q <= UNIT_UPPER_IMM;
         rd_q <= '0;
      end else begin
         illegal_q <= 1'b0;
         case (state)
            IDLE: if (bus.instr_valid) begin
               if (sel_illegal) illegal_q <= 1'b1;
               else begin
                  state <= EXEC;
                  ready_q <= 1'b0;
                  sel_q <= sel_unit;
                  rd_q <= bus.rd_index;
                  count <= '0;
                  enable_q <= NUM_UNITS'(1) << sel_unit;
               end
            end
            EXEC: if (count == LAST) begin
               enable_q <= '0;
               count <= '0;
               wb_value_q <= bus.unit_result[{sel_q, 5'd0} +: 32];
               // x0 results are discarded, so writeback is skipped entirely
               if (rd_q == 5'd0) begin
                  state <= IDLE;
                  ready_q <= 1'b1;
               end else begin
                  state <= WB;
                  wb_valid_q <= 1'b1;
                  wb_rd_q <= rd_q;
               end
            end else count <= count + 3'd1;
            WB: if (bus.wb_ready) begin
               state <= IDLE;
               ready_q <= 1'b1;
               wb_valid_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign bus.instr_ready = ready_q;
   assign bus.unit_enable = enable_q;
   assign bus.wb_valid = wb_valid_q;
   assign bus.wb_rd_index = wb_rd_q;
   assign bus.wb_value = wb_value_q;
   assign bus.illegal_opcode = illegal_q;
`ifdef ALU_DISPATCH_PERF_COUNTERS_EN
   logic [31:0] issued_q, stall_q;
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         issued_q <= '0;
         stall_q <= '0;
      end else begin
         issued_q <= issued_q + 32'(state == IDLE && bus.instr_valid && !sel_illegal);
         stall_q <= stall_q + 32'(state == WB && !bus.wb_ready);
      end
   end
   assign bus.perf_issued = issued_q;
   assign bus.perf_wb_stall = stall_q;
`endif
endmodule

// File: tb/tb_alu_dispatch_controller.sv
// tb_alu_dispatch_controller: table-driven, hand-written and random checks of the dispatch controller
module tb_alu_dispatch_controller;
   localparam int LAT = 3;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;
   alu_dispatch_controller_if #(.NUM_UNITS(3)) bus();
   alu_dispatch_controller #(.UNIT_LATENCY(LAT), .NUM_UNITS(3)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
   int checks = 0;
   int errors = 0;
   int exp_issued = 0;
   int exp_stall = 0;
   typedef struct {
      logic [6:0] opcode;
      logic [4:0] rd;
      int stall;
      logic [95:0] res;
      logic [2:0] exp_en;
      logic [31:0] exp_val;
   } vec_t;
   vec_t vecs[6];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'd0, act}, {31'd0, exp});
   endtask
   task automatic chk_perf();
`ifdef ALU_DISPATCH_PERF_COUNTERS_EN
      chk("perf_issued", bus.perf_issued, 32'(exp_issued));
      chk("perf_wb_stall", bus.perf_wb_stall, 32'(exp_stall));
`endif
   endtask
   function automatic int unit_of(input logic [6:0] op);
      return (op == 7'h37 || op == 7'h17) ? 0 : (op == 7'h13) ? 1 : (op == 7'h33) ? 2 : -1;
   endfunction
   // Issue one instruction from IDLE and follow it until the controller is back in IDLE
   task automatic run_instr(input logic [6:0] op, input logic [4:0] rd, input int stall,
                            input logic [95:0] res, input logic [2:0] exp_en, input logic [31:0] exp_val);
      chk1("ready_idle", bus.instr_ready, 1'b1);
      bus.instr_valid = 1'b1;
      bus.opcode = op;
      bus.rd_index = rd;
      bus.unit_result = res;
      @(negedge clock);
      bus.instr_valid = 1'b0;
      if (exp_en == 3'b000) begin
         chk1("illegal_pulse", bus.illegal_opcode, 1'b1);
         chk("illegal_enable", 32'(bus.unit_enable), 32'd0);
         chk1("illegal_wb_valid", bus.wb_valid, 1'b0);
         chk1("illegal_ready", bus.instr_ready, 1'b1);
         @(negedge clock);
         chk1("illegal_once", bus.illegal_opcode, 1'b0);
         chk("illegal_enable_after", 32'(bus.unit_enable), 32'd0);
         chk_perf();
         return;
      end
      exp_issued++;
      for (int i = 0; i < LAT; i++) begin
         chk("exec_enable", 32'(bus.unit_enable), 32'(exp_en));
         chk1("exec_ready", bus.instr_ready, 1'b0);
         chk1("exec_wb_valid", bus.wb_valid, 1'b0);
         chk1("exec_illegal", bus.illegal_opcode, 1'b0);
         bus.wb_ready = 1'($urandom);
         bus.instr_valid = 1'($urandom);
         bus.opcode = 7'($urandom);
         bus.rd_index = 5'($urandom);
         @(negedge clock);
      end
      bus.instr_valid = 1'b0;
      if (rd != 5'd0) begin
         for (int s = 0; s <= stall; s++) begin
            chk1("wb_valid", bus.wb_valid, 1'b1);
            chk("wb_rd_index", 32'(bus.wb_rd_index), 32'(rd));
            chk("wb_value", bus.wb_value, exp_val);
            chk("wb_enable", 32'(bus.unit_enable), 32'd0);
            chk1("wb_ready_low", bus.instr_ready, 1'b0);
            bus.wb_ready = (s == stall);
            if (s < stall) exp_stall++;
            @(negedge clock);
         end
      end
      chk1("done_wb_valid", bus.wb_valid, 1'b0);
      chk1("done_ready", bus.instr_ready, 1'b1);
      chk("done_enable", 32'(bus.unit_enable), 32'd0);
      bus.wb_ready = 1'b0;
      chk_perf();
   endtask
   initial begin
      int seen;
      int first_b;
      int wb_n;
      int viol;
      int wc[2];
      logic [4:0] wr[2];
      logic [31:0] wv[2];
      logic [95:0] res;
      logic [6:0] op;
      logic [4:0] rd;
      int u;
      vecs[0] = '{7'h37, 5'd5, 0, {32'hAAAA0002, 32'h55550001, 32'h12345000}, 3'b001, 32'h12345000};
      vecs[1] = '{7'h33, 5'd7, 4, {32'hCAFEF00D, 32'h00001111, 32'h00002222}, 3'b100, 32'hCAFEF00D};
      vecs[2] = '{7'h03, 5'd9, 0, {32'h1, 32'h2, 32'h3}, 3'b000, 32'h0};
      vecs[3] = '{7'h13, 5'd0, 0, {32'h4, 32'h5, 32'h6}, 3'b010, 32'h0};
      vecs[4] = '{7'h17, 5'd31, 1, {32'h7, 32'h8, 32'h00400ABC}, 3'b001, 32'h00400ABC};
      vecs[5] = '{7'h7F, 5'd1, 0, {32'h9, 32'hA, 32'hB}, 3'b000, 32'h0};
      bus.instr_valid = 1'b0;
      bus.opcode = 7'h0;
      bus.rd_index = 5'd0;
      bus.unit_result = '0;
      bus.wb_ready = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk1("rst_ready", bus.instr_ready, 1'b1);
      chk("rst_enable", 32'(bus.unit_enable), 32'd0);
      chk1("rst_wb_valid", bus.wb_valid, 1'b0);
      chk("rst_wb_rd", 32'(bus.wb_rd_index), 32'd0);
      chk("rst_wb_value", bus.wb_value, 32'd0);
      chk1("rst_illegal", bus.illegal_opcode, 1'b0);
      chk_perf();
      reset_n = 1'b1;
      // Reset in the middle of EXEC must abort the instruction without writeback
      bus.instr_valid = 1'b1;
      bus.opcode = 7'h33;
      bus.rd_index = 5'd12;
      bus.unit_result = {32'hDEAD0001, 32'h2, 32'h3};
      @(negedge clock);
      bus.instr_valid = 1'b0;
      chk("mid_enable", 32'(bus.unit_enable), 32'b100);
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      chk("abort_enable", 32'(bus.unit_enable), 32'd0);
      chk1("abort_wb_valid", bus.wb_valid, 1'b0);
      chk1("abort_ready", bus.instr_ready, 1'b1);
      chk("abort_wb_value", bus.wb_value, 32'd0);
      reset_n = 1'b1;
      bus.wb_ready = 1'b1;
      seen = 0;
      repeat (LAT + 4) begin
         @(negedge clock);
         if (bus.wb_valid) seen++;
      end
      chk("abort_no_wb", 32'(seen), 32'd0);
      bus.wb_ready = 1'b0;
      chk_perf();
      for (int i = 0; i < 6; i++)
         run_instr(vecs[i].opcode, vecs[i].rd, vecs[i].stall, vecs[i].res, vecs[i].exp_en, vecs[i].exp_val);
      // AUIPC then OP-IMM with instr_valid held high throughout
      bus.wb_ready = 1'b1;
      bus.instr_valid = 1'b1;
      bus.opcode = 7'h17;
      bus.rd_index = 5'd3;
      bus.unit_result = {32'h00000333, 32'h00000222, 32'h00001000};
      first_b = -1;
      wb_n = 0;
      viol = 0;
      for (int c = 1; c <= 2 * LAT + 6; c++) begin
         @(negedge clock);
         if (c == 1) begin
            bus.opcode = 7'h13;
            bus.rd_index = 5'd4;
         end
         if ($countones(bus.unit_enable) > 1) viol++;
         if (bus.unit_enable == 3'b010 && first_b < 0) begin
            first_b = c;
            bus.instr_valid = 1'b0;
         end
         if (bus.wb_valid && wb_n < 2) begin
            wc[wb_n] = c;
            wr[wb_n] = bus.wb_rd_index;
            wv[wb_n] = bus.wb_value;
            wb_n++;
         end
      end
      exp_issued += 2;
      chk("b2b_onehot", 32'(viol), 32'd0);
      chk("b2b_second_start", 32'(first_b), 32'(LAT + 3));
      chk("b2b_wb_count", 32'(wb_n), 32'd2);
      if (wb_n == 2) begin
         chk("b2b_wb0_cycle", 32'(wc[0]), 32'(LAT + 1));
         chk("b2b_wb0_rd", 32'(wr[0]), 32'd3);
         chk("b2b_wb0_value", wv[0], 32'h00001000);
         chk("b2b_wb1_cycle", 32'(wc[1]), 32'(2 * LAT + 3));
         chk("b2b_wb1_rd", 32'(wr[1]), 32'd4);
         chk("b2b_wb1_value", wv[1], 32'h00000222);
      end
      bus.wb_ready = 1'b0;
      chk_perf();
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 5))
            0: op = 7'h37;
            1: op = 7'h17;
            2: op = 7'h13;
            3: op = 7'h33;
            default: op = 7'($urandom);
         endcase
         rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         res = {$urandom, $urandom, $urandom};
         u = unit_of(op);
         if (u < 0) run_instr(op, rd, 0, res, 3'b000, 32'd0);
         else run_instr(op, rd, $urandom_range(0, 3), res, 3'(1 << u), res[u*32 +: 32]);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
